// File: rtl/queued_instruction_decoder.sv
// queued_instruction_decoder
// Buffers fetched 16-bit instructions in a small FIFO and feeds them one at a
// time into a registered decode stage. The FSM controller pulls instructions
// with a valid/ready handshake. Decoded fields and register selects are
// derived combinationally from the held instruction only, so they stay stable
// while the controller works on it.
module queued_instruction_decoder #(
    parameter int DATAW = 16,
    parameter int DEPTH = 2,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [15:0]      in_instr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dec_valid,
    input  logic             dec_ready,
    input  logic [2:0]       nsel,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [1:0]       ALUop,
    output logic [1:0]       shift,
    output logic [DATAW-1:0] sximm5,
    output logic [DATAW-1:0] sximm8,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic [CNTW-1:0]  count,
    output logic             nsel_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW-1:0] FULL_C = CNTW'(DEPTH);

    localparam logic [2:0] NSEL_IDLE_C = 3'b000;
    localparam logic [2:0] NSEL_RM_C   = 3'b001;
    localparam logic [2:0] NSEL_RD_C   = 3'b010;
    localparam logic [2:0] NSEL_RN_C   = 3'b100;

    logic [15:0]     mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CNTW-1:0] count_r;
    logic [15:0]     cur_r;
    logic            dec_valid_r;
    logic            nsel_err_r;

    logic            in_ready_s;
    logic            push_s;
    logic            ld_s;
    logic            nsel_bad_s;
    logic [2:0]      regnum_s;

    // No push when full, even if the head is being loaded this cycle; a
    // flushed cycle never accepts data.
    assign in_ready_s = (count_r != FULL_C);
    assign push_s     = in_valid & in_ready_s & ~flush;
    assign ld_s       = (count_r != {CNTW{1'b0}}) & (~dec_valid_r | dec_ready);

    // Legal selects are idle or exactly one-hot.
    assign nsel_bad_s = (nsel != NSEL_IDLE_C) && (nsel != NSEL_RM_C) &&
                        (nsel != NSEL_RD_C)   && (nsel != NSEL_RN_C);

    // FIFO storage write; data needs no reset since pointers/count gate it.
    always_ff @(posedge clk) begin
        if (reset_n && push_s) begin
            mem_r[wr_ptr_r] <= in_instr;
        end
    end

    // FIFO control, decode stage and sticky select-error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CNTW{1'b0}};
            cur_r       <= 16'h0000;
            dec_valid_r <= 1'b0;
            nsel_err_r  <= 1'b0;
        end else if (flush) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CNTW{1'b0}};
            dec_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (ld_s) begin
                cur_r       <= mem_r[rd_ptr_r];
                dec_valid_r <= 1'b1;
                rd_ptr_r    <= rd_ptr_r + PW'(1);
            end else if (dec_valid_r && dec_ready) begin
                dec_valid_r <= 1'b0;
            end
            count_r <= count_r + CNTW'(push_s) - CNTW'(ld_s);
            if (dec_valid_r && nsel_bad_s) begin
                nsel_err_r <= 1'b1;
            end
        end
    end

    // Register index from the one-hot select; anything illegal reads R0.
    always_comb begin
        regnum_s = 3'b000;
        case (nsel)
            NSEL_RM_C: regnum_s = cur_r[2:0];
            NSEL_RD_C: regnum_s = cur_r[7:5];
            NSEL_RN_C: regnum_s = cur_r[10:8];
            default:   regnum_s = 3'b000;
        endcase
    end

    assign in_ready  = in_ready_s;
    assign dec_valid = dec_valid_r;
    assign count     = count_r;
    assign nsel_err  = nsel_err_r;
    assign opcode    = cur_r[15:13];
    assign op        = cur_r[12:11];
    assign ALUop     = cur_r[12:11];
    assign shift     = cur_r[4:3];
    assign sximm5    = {{(DATAW-5){cur_r[4]}}, cur_r[4:0]};
    assign sximm8    = {{(DATAW-8){cur_r[7]}}, cur_r[7:0]};
    assign readnum   = regnum_s;
    assign writenum  = regnum_s;

endmodule
